serv_sram_ctrl: RTL and testbench

Single-port synchronous-SRAM controller that sits directly downstream of the SERV core's instruction and data buses and serves both from one memory. It arbitrates between ibus and dbus, drives a byte-writable SRAM with configurable read latency, and returns registered read data with one-cycle ack pulses matching the core's cyc/ack handshake.

---
 rtl/serv_sram_ctrl.sv | 123 ++++++++++++
 tb/tb_serv_sram_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_sram_ctrl.sv
// Single-port SRAM controller arbitrating SERV ibus/dbus (dbus wins ties).
// Optional SERV_SRAM_RANGE_CHECK_EN: block out-of-range accesses and raise sticky o_err.
module serv_sram_ctrl #(
  parameter int unsigned MEM_AW = 13,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_ibus_adr,
  input  logic              i_ibus_cyc,
  output logic [31:0]       o_ibus_rdt,
  output logic              o_ibus_ack,
  input  logic [31:0]       i_dbus_adr,
  input  logic [31:0]       i_dbus_dat,
  input  logic [3:0]        i_dbus_sel,
  input  logic              i_dbus_we,
  input  logic              i_dbus_cyc,
  output logic [31:0]       o_dbus_rdt,
  output logic              o_dbus_ack,
  output logic [MEM_AW-3:0] o_mem_adr,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [31:0]       o_mem_wdat,
  input  logic [31:0]       i_mem_rdat,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t      state, next_state;
  logic [1:0]  cnt;
  logic        gnt_d;
  logic        we_l;
  logic        oor_l;
  logic        req;
  logic        pick_d;
  logic [31:0] pick_adr;
  logic        pick_oor;
  logic        unused_adr_bits;

  assign req      = i_ibus_cyc | i_dbus_cyc;
  assign pick_d   = i_dbus_cyc;
  assign pick_adr = pick_d ? i_dbus_adr : i_ibus_adr;
  assign unused_adr_bits = ^{pick_adr[1:0], pick_adr[31:MEM_AW]};

`ifdef SERV_SRAM_RANGE_CHECK_EN
  assign pick_oor = |pick_adr[31:MEM_AW];
`else
  assign pick_oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = ISSUE;
      ISSUE:   next_state = we_l ? ACK : WAIT;
      WAIT:    if (cnt == 2'd0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // SRAM strobes are registered on IDLE exit so they are high exactly during ISSUE.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      gnt_d      <= 1'b0;
      we_l       <= 1'b0;
      oor_l      <= 1'b0;
      o_mem_adr  <= '0;
      o_mem_wdat <= '0;
      o_mem_en   <= 1'b0;
      o_mem_we   <= '0;
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      o_ibus_rdt <= '0;
      o_dbus_rdt <= '0;
    end else begin
      o_mem_en   <= 1'b0;
      o_mem_we   <= '0;
      o_ibus_ack <= (next_state == ACK) && !gnt_d;
      o_dbus_ack <= (next_state == ACK) && gnt_d;
      case (state)
        IDLE: begin
          if (req) begin
            gnt_d     <= pick_d;
            we_l      <= pick_d & i_dbus_we;
            oor_l     <= pick_oor;
            o_mem_adr <= pick_adr[MEM_AW-1:2];
            if (pick_d) o_mem_wdat <= i_dbus_dat;
            o_mem_en  <= !pick_oor;
            o_mem_we  <= (pick_d && i_dbus_we && !pick_oor) ? i_dbus_sel : '0;
          end
        end
        ISSUE: cnt <= 2'(RD_LAT - 1);
        WAIT: begin
          if (cnt == 2'd0) begin
            if (gnt_d) o_dbus_rdt <= oor_l ? '0 : i_mem_rdat;
            else       o_ibus_rdt <= oor_l ? '0 : i_mem_rdat;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERV_SRAM_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                          o_err <= 1'b0;
    else if (next_state == ACK && oor_l)   o_err <= 1'b1;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_serv_sram_ctrl.sv
// Self-checking bench for serv_sram_ctrl: RD_LAT=1 and RD_LAT=3 instances with bench SRAM models.
module tb_serv_sram_ctrl;

`ifdef SERV_SRAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_adr, dbus_adr, dbus_dat;
  logic        ibus_cyc, dbus_cyc, dbus_we;
  logic [3:0]  dbus_sel;

  logic [31:0] a_ibus_rdt, a_dbus_rdt, a_mem_wdat, a_mem_rdat;
  logic        a_ibus_ack, a_dbus_ack, a_mem_en, a_err;
  logic [3:0]  a_mem_we;
  logic [10:0] a_mem_adr;

  logic [31:0] b_ibus_rdt, b_dbus_rdt, b_mem_wdat, b_mem_rdat;
  logic        b_ibus_ack, b_dbus_ack, b_mem_en, b_err;
  logic [3:0]  b_mem_we;
  logic [10:0] b_mem_adr;
  logic [31:0] b_p1, b_p2;

  logic [31:0] mem_a [2048] = '{default: '0};
  logic [31:0] mem_b [2048] = '{default: '0};

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serv_sram_ctrl #(.MEM_AW(13), .RD_LAT(1)) dut_a (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(a_ibus_rdt), .o_ibus_ack(a_ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(a_dbus_rdt), .o_dbus_ack(a_dbus_ack),
    .o_mem_adr(a_mem_adr), .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_wdat(a_mem_wdat),
    .i_mem_rdat(a_mem_rdat), .o_err(a_err)
  );

  serv_sram_ctrl #(.MEM_AW(13), .RD_LAT(3)) dut_b (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(b_ibus_rdt), .o_ibus_ack(b_ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(b_dbus_rdt), .o_dbus_ack(b_dbus_ack),
    .o_mem_adr(b_mem_adr), .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_wdat(b_mem_wdat),
    .i_mem_rdat(b_mem_rdat), .o_err(b_err)
  );

  // Latency-1 SRAM; garbage on the read port whenever the previous edge was not enabled.
  always @(posedge clk) begin
    if (a_mem_en) begin
      for (int i = 0; i < 4; i++)
        if (a_mem_we[i]) mem_a[a_mem_adr][8*i +: 8] <= a_mem_wdat[8*i +: 8];
      a_mem_rdat <= mem_a[a_mem_adr];
    end else begin
      a_mem_rdat <= 32'hBAD0BAD0;
    end
  end

  // Latency-3 SRAM, preloaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_b[5] <= 32'h55AA1234;
      mem_b[6] <= 32'h0BADF00D;
    end else if (b_mem_en) begin
      for (int i = 0; i < 4; i++)
        if (b_mem_we[i]) mem_b[b_mem_adr][8*i +: 8] <= b_mem_wdat[8*i +: 8];
    end
    b_p1       <= b_mem_en ? mem_b[b_mem_adr] : 32'hBAD0BAD0;
    b_p2       <= b_p1;
    b_mem_rdat <= b_p2;
  end

  typedef struct {
    bit          dbus;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;
    bit          exp_en;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the transaction.
  task automatic do_txn(input vec_t v, input string nm);
    int          ack_c = -1;
    logic [31:0] rdt = '0;
    if (v.dbus) begin
      dbus_adr = v.adr; dbus_dat = v.dat; dbus_sel = v.sel; dbus_we = v.we; dbus_cyc = 1'b1;
    end else begin
      ibus_adr = v.adr; ibus_cyc = 1'b1;
    end
    for (int c = 0; c < 12 && ack_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({nm, ".mem_en"}, 32'(a_mem_en), 32'(v.exp_en));
        chk({nm, ".mem_we"}, 32'(a_mem_we), (v.we && v.exp_en) ? 32'(v.sel) : 32'h0);
        chk({nm, ".mem_adr"}, 32'(a_mem_adr), 32'(v.adr[12:2]));
        if (v.we) chk({nm, ".mem_wdat"}, a_mem_wdat, v.dat);
      end
      if (v.dbus ? a_dbus_ack : a_ibus_ack) begin
        ack_c = c;
        rdt = v.dbus ? a_dbus_rdt : a_ibus_rdt;
      end
      @(posedge clk); #1;
    end
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;
    chk({nm, ".ack_cycle"}, 32'(ack_c), v.we ? 32'd2 : 32'd3);
    chk({nm, ".rdt"}, rdt, v.exp_rdt);
    @(posedge clk); #1;
  endtask

  task automatic b_read(input bit is_d, input logic [31:0] adr, input int drop_c,
                        input logic [31:0] exp, input string nm);
    int          ack_c = -1;
    int          n_ack = 0;
    logic [31:0] rdt = '0;
    dbus_we = 1'b0;
    if (is_d) begin dbus_adr = adr; dbus_cyc = 1'b1; end
    else      begin ibus_adr = adr; ibus_cyc = 1'b1; end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (is_d ? b_dbus_ack : b_ibus_ack) begin
        n_ack++;
        if (ack_c < 0) begin
          ack_c = c;
          rdt = is_d ? b_dbus_rdt : b_ibus_rdt;
        end
      end
      @(posedge clk); #1;
      if (c + 1 == drop_c) begin ibus_cyc = 1'b0; dbus_cyc = 1'b0; end
    end
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    chk({nm, ".ack_cycle"}, 32'(ack_c), 32'd5);
    chk({nm, ".ack_count"}, 32'(n_ack), 32'd1);
    chk({nm, ".rdt"}, rdt, exp);
  endtask

  initial begin
    int          d_ack_c, i_ack_c, d_n, i_n, n_ack;
    logic [31:0] d_rdt, i_rdt, en_mask;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'h0,        1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000AB00, 4'h2, 32'h0,        1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'h1122AB44, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'h1122AB44, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_1FFC, 32'hCAFEF00D, 4'h9, 32'h1122AB44, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,        4'hF, 32'hCA00000D, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_2010, 32'h0,        4'hF, RC ? 32'h0 : 32'hDEADBEEF, !RC};

    rst_n = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.acks_en", {29'b0, a_ibus_ack, a_dbus_ack, a_mem_en}, 32'h0);
    chk("reset.mem_we", 32'(a_mem_we), 32'h0);
    chk("reset.err", 32'(a_err), 32'h0);
    chk("reset.ibus_rdt", a_ibus_rdt, 32'h0);
    chk("reset.dbus_rdt", a_dbus_rdt, 32'h0);
    chk("reset.mem_adr", 32'(a_mem_adr), 32'h0);
    chk("reset.mem_wdat", a_mem_wdat, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
    chk("ibus_rdt_hold", a_ibus_rdt, 32'h1122AB44);
    chk("err_after_alias", 32'(a_err), 32'(RC));

    // Simultaneous requests: dbus first, ibus granted in the IDLE after dbus ACK.
    d_ack_c = -1; i_ack_c = -1; d_n = 0; i_n = 0; en_mask = '0; d_rdt = '0; i_rdt = '0;
    dbus_adr = 32'h10; dbus_we = 1'b0; dbus_sel = 4'hF; ibus_adr = 32'h20;
    dbus_cyc = 1'b1; ibus_cyc = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_mem_en) en_mask[c] = 1'b1;
      if (a_dbus_ack) begin d_n++; if (d_ack_c < 0) begin d_ack_c = c; d_rdt = a_dbus_rdt; end end
      if (a_ibus_ack) begin i_n++; if (i_ack_c < 0) begin i_ack_c = c; i_rdt = a_ibus_rdt; end end
      @(posedge clk); #1;
      if (d_n > 0) dbus_cyc = 1'b0;
      if (i_n > 0) ibus_cyc = 1'b0;
    end
    dbus_cyc = 1'b0; ibus_cyc = 1'b0;
    chk("arb.dbus_ack_cycle", 32'(d_ack_c), 32'd3);
    chk("arb.ibus_ack_cycle", 32'(i_ack_c), 32'd7);
    chk("arb.ack_counts", 32'(d_n * 16 + i_n), 32'h11);
    chk("arb.en_cycles", en_mask, 32'h22);
    chk("arb.dbus_rdt", d_rdt, 32'hDEADBEEF);
    chk("arb.ibus_rdt", i_rdt, 32'h1122AB44);
    chk("err_sticky", 32'(a_err), 32'(RC));

    // Reset during WAIT aborts the read without an ack.
    dbus_adr = 32'h10; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait.acks_en", {29'b0, a_ibus_ack, a_dbus_ack, a_mem_en}, 32'h0);
    chk("rst_wait.dbus_rdt", a_dbus_rdt, 32'h0);
    chk("rst_wait.ibus_rdt", a_ibus_rdt, 32'h0);
    chk("rst_wait.err", 32'(a_err), 32'h0);
    dbus_cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_ibus_ack || a_dbus_ack) n_ack++;
    end
    chk("rst_wait.no_ack", 32'(n_ack), 32'h0);
    @(posedge clk); #1;
    do_txn('{1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1}, "post_rst_read");

    // Reset during ISSUE of a write drops the SRAM write.
    dbus_adr = 32'h30; dbus_dat = 32'h12345678; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
    @(posedge clk); #1;
    chk("rst_issue.en_before", 32'(a_mem_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_issue.en_after", 32'(a_mem_en), 32'h0);
    chk("rst_issue.we_after", 32'(a_mem_we), 32'h0);
    dbus_cyc = 1'b0; dbus_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn('{1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b1}, "dropped_write");

    // RD_LAT=3 instance: cyc dropped in cycle 2 still acks in cycle 5, then a normal read.
    repeat (8) @(posedge clk);
    #1;
    b_read(1'b0, 32'h14, 2, 32'h55AA1234, "lat3_drop");
    b_read(1'b1, 32'h18, 6, 32'h0BADF00D, "lat3_read");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
